scope_capture: RTL and testbench
================================

# scope_capture

Triggered sample-capture stage that sits directly downstream of the sine/cosine generator. It watches one 8-bit sample stream for a rising crossing of a programmable level, then records a fixed-length window of samples into internal RAM. It then streams the window out over a valid/ready interface to the display/plot stage, giving a stable, triggered waveform like an oscilloscope.

## Interface
- DATA_WIDTH, 8, sample width in bits
- ADDR_WIDTH, 8, log2 of capture depth; DEPTH = 2**ADDR_WIDTH samples

- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- din  in  DATA_WIDTH  sample from generator (data1 or data2)
- din_valid  in  1  din is a new sample this cycle
- level  in  DATA_WIDTH  trigger level, unsigned
- arm  in  1  single-cycle request to start a capture
- force_trig  in  1  level-sensitive; while ARMED, trigger on next valid sample regardless of level
- out_data  out  DATA_WIDTH  captured sample being presented
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data this cycle
- out_last  out  1  presented sample is index DEPTH-1
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after final readout transfer

## Operation
- States: IDLE, ARMED, CAPTURE, READOUT; encoded internally, not exported.
- IDLE: outputs quiescent. arm=1 -> ARMED, prev_ok cleared.
- ARMED: each din_valid sample updates prev (registered previous sample) and sets prev_ok. Trigger condition on a valid sample: force_trig=1, or (prev_ok and prev < level and din >= level), unsigned compares. On trigger the triggering sample is written to address 0, wr_ptr <= 1, -> CAPTURE. First valid sample after arming can only trigger via force_trig.
- CAPTURE: each din_valid writes din at wr_ptr, wr_ptr increments. The write to address DEPTH-1 moves to READOUT next cycle. Samples without din_valid are ignored. No wrap; exactly DEPTH samples stored, index 0 = trigger sample.
- READOUT: presents addresses 0..DEPTH-1 in order. Transfer occurs when out_valid and out_ready. out_last=1 exactly while address DEPTH-1 is presented. out_data/out_valid hold stable while out_ready=0. After the last transfer: done pulses, -> IDLE.
- RAM: single-clock, one write port, one synchronous read port, DEPTH x DATA_WIDTH. Contents not cleared by reset.
- arm is ignored in ARMED, CAPTURE and READOUT; no re-arm or abort except via rst.
- din/din_valid are ignored in READOUT and IDLE.
- Reset mid-operation: immediate return to IDLE; pointers cleared. RAM keeps stale data but is never read without a fresh capture.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- busy rises the cycle after arm is sampled in IDLE. It falls in the same cycle done is high.
- Trigger sample write and the ARMED->CAPTURE transition occur on the same edge that samples the trigger.
- READOUT entry: out_valid first asserts exactly 2 cycles after the edge that writes address DEPTH-1, which allows one cycle of RAM read latency.
- Throughput: with out_ready held high, one transfer per cycle, no bubbles. Requires a prefetch/skid register. DEPTH transfers complete in DEPTH consecutive cycles.
- out_ready toggling: no sample is dropped or duplicated. Sequence is strictly 0..DEPTH-1.
- done asserts the cycle after the final transfer, for one cycle. out_valid=0 in that cycle.

## Test plan
- Basic trigger (ADDR_WIDTH=4): ramp din 0,10,20,...,250 every cycle, level=100, arm pulse. Captured stream must be 100,110,...,250, one per cycle with out_ready=1. out_last on 250; done one cycle later.
- No false trigger: arm, then din constant 200 with level=100. Must stay ARMED (busy=1, out_valid=0) for 100 cycles. Then din 50,150 -> triggers on 150, index 0 = 150.
- force_trig: arm with din constant 5, level=200, force_trig=1. The first valid sample (5) triggers, and all 16 captured values are 5.
- Gapped input and backpressure: din_valid 1-in-3, out_ready random 50%. Stream must equal the valid samples in order starting at the trigger, with no duplicates or drops. out_data must stay stable while stalled.
- Ignored arm and reset mid-readout: pulse arm during CAPTURE -> no effect. Assert rst at readout index 7 -> next cycle out_valid=0, busy=0. A new arm then captures a fresh window correctly.
- Full depth (ADDR_WIDTH=8): 256-sample sine from generator with level=128. Word 0 >= 128 and the previous sample < 128. Exactly 256 transfers, then done.

Source files
------------

// File: rtl/scope_capture_if.sv
// scope_capture_if: sample stream from the capture stage to the display/plot stage.
//
// Handshake: a word moves on every rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid, out_data and
// out_last stay unchanged until that transfer happens. out_ready may toggle
// freely, and out_valid never depends combinationally on out_ready.
//
// Signals:
//   out_data  - captured sample being presented
//   out_valid - out_data holds a word
//   out_ready - consumer accepts out_data this cycle
//   out_last  - presented word is the final index of the window
// Modports: master (capture stage), slave (consumer).
interface scope_capture_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/scope_capture.sv
// scope_capture: triggered sample-capture stage.
//
// The block waits for arm, then watches din for a rising crossing of level
// (or takes any sample while force_trig is held). It records 2**ADDR_WIDTH
// samples into internal RAM, with index 0 holding the trigger sample, and then
// streams the window out over out_if.
//
// Ports:
//   clk, rst    - rising-edge clock; asynchronous active-high reset
//   din         - input sample; din_valid marks a new sample
//   level       - unsigned trigger level
//   arm         - one-cycle request to start a capture (seen only in IDLE)
//   force_trig  - while ARMED, the next valid sample triggers
//   out_if      - master side of the readout stream
//   busy        - state is not IDLE
//   done        - one-cycle pulse after the final readout transfer
module scope_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] level,
  input  logic                  arm,
  input  logic                  force_trig,
  scope_capture_if.master       out_if,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   RD_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_ok_q, prev_ok_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;   // MSB set once every address has been read
  logic                  rd_pend_q, rd_pend_d;   // ram_q carries a word this cycle
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;   // index of the word on out_data
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic                  trig;
  logic                  xfer;
  logic [1:0]            occ;
  logic [1:0]            avail;

  assign trig  = force_trig | (prev_ok_q & (prev_q < level) & (din >= level));
  assign xfer  = out_valid_q & out_if.out_ready;
  // Words held or in flight, and what remains after this cycle's transfer.
  // A read is issued only when the output and skid registers can still hold
  // its result, so a word returned by the RAM always has a place to go.
  assign occ   = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
  assign avail = occ - 2'(xfer);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_ok_d    = prev_ok_q;
    wr_ptr_d     = wr_ptr_q;
    rd_addr_d    = rd_addr_q;
    rd_pend_d    = 1'b0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    out_cnt_d    = out_cnt_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;
    rd_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d      = S_ARMED;
          prev_ok_d    = 1'b0;
          wr_ptr_d     = '0;
          rd_addr_d    = '0;
          out_cnt_d    = '0;
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end
      end

      S_ARMED: begin
        if (din_valid) begin
          prev_d    = din;
          prev_ok_d = 1'b1;
          if (trig) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_ptr_d = ADDR_ONE;
            state_d  = S_CAPTURE;
          end
        end
      end

      S_CAPTURE: begin
        if (din_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_ONE;
          if (wr_ptr_q == LAST_ADDR) state_d = S_READOUT;
        end
      end

      S_READOUT: begin
        if (!rd_addr_q[ADDR_WIDTH] && (avail < 2'd2)) begin
          rd_en     = 1'b1;
          rd_pend_d = 1'b1;
          rd_addr_d = rd_addr_q + RD_ONE;
        end

        // Refill order: skid first (it is older), then the word leaving the RAM.
        if (xfer) begin
          if (skid_valid_q) begin
            out_data_d   = skid_q;
            out_valid_d  = 1'b1;
            skid_d       = ram_q;
            skid_valid_d = rd_pend_q;
          end else begin
            if (rd_pend_q) out_data_d = ram_q;
            out_valid_d = rd_pend_q;
          end
        end else if (!out_valid_q) begin
          if (rd_pend_q) out_data_d = ram_q;
          out_valid_d = rd_pend_q;
        end else if (rd_pend_q) begin
          skid_d       = ram_q;
          skid_valid_d = 1'b1;
        end

        if (xfer) begin
          out_cnt_d = out_cnt_q + ADDR_ONE;
          if (out_cnt_q == LAST_ADDR) begin
            state_d      = S_IDLE;
            done_d       = 1'b1;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      out_cnt_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_addr_q    <= rd_addr_d;
      rd_pend_q    <= rd_pend_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      out_cnt_q    <= out_cnt_d;
      done_q       <= done_d;
    end
  end

  // Capture RAM: contents survive reset and are only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
    if (rd_en) ram_q <= mem[rd_addr_q[ADDR_WIDTH-1:0]];
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_valid_q & (out_cnt_q == LAST_ADDR);
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: a 16-deep instance runs the directed scenarios, and
// a 256-deep instance captures a full sine window.
module tb_scope_capture;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] level;
  logic       force_trig;
  logic       arm4, arm8;
  logic       busy4, done4, busy8, done8;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sine[400];

  scope_capture_if #(.DATA_WIDTH(8)) if4 ();
  scope_capture_if #(.DATA_WIDTH(8)) if8 ();

  scope_capture #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .level(level),
    .arm(arm4), .force_trig(force_trig), .out_if(if4), .busy(busy4), .done(done4)
  );

  scope_capture #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .level(level),
    .arm(arm8), .force_trig(force_trig), .out_if(if8), .busy(busy8), .done(done8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_sample(input logic [7:0] d, input logic v);
    @(negedge clk);
    din       = d;
    din_valid = v;
  endtask

  task automatic arm_dut(input bit sel8);
    @(negedge clk);
    if (sel8) arm8 = 1'b1; else arm4 = 1'b1;
    @(negedge clk);
    arm4 = 1'b0;
    arm8 = 1'b0;
    check(sel8 ? "busy8_after_arm" : "busy4_after_arm", sel8 ? busy8 : busy4, 1);
  endtask

  // Drains exp_q from the chosen instance. stop_at >= 0 stops while that index
  // is presented (without transferring it) and skips the done checks.
  task automatic readout(input bit sel8, input bit rnd, input int stop_at,
                         output int n_xfer, output int span, output logic [7:0] first_word);
    int         cyc = 0;
    int         first_c = -1;
    int         last_c = 0;
    bit         rdy;
    bit         stalled = 1'b0;
    bit         stop = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] d, e;
    logic       v, l;
    n_xfer = 0;
    span = 0;
    first_word = '0;
    while (exp_q.size() > 0 && cyc < 3000 && !stop) begin
      @(negedge clk);
      cyc++;
      v = sel8 ? if8.out_valid : if4.out_valid;
      d = sel8 ? if8.out_data  : if4.out_data;
      l = sel8 ? if8.out_last  : if4.out_last;
      if (stalled) begin
        check("stall_valid", v, 1);
        check("stall_data", d, held);
      end
      if (v && n_xfer == stop_at) begin
        check("stop_data", d, exp_q[0]);
        stop = 1'b1;
        rdy  = 1'b0;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (sel8) if8.out_ready = rdy; else if4.out_ready = rdy;
      if (v && rdy) begin
        e = exp_q.pop_front();
        check("data", d, e);
        check("last", l, (exp_q.size() == 0));
        if (first_c < 0) begin
          first_c    = cyc;
          first_word = d;
        end
        last_c = cyc;
        n_xfer++;
        stalled = 1'b0;
      end else begin
        stalled = v;
        held    = d;
      end
    end
    if (!stop) check("readout_left", exp_q.size(), 0);
    span = last_c - first_c;
    if (!stop) begin
      @(negedge clk);
      if4.out_ready = 1'b0;
      if8.out_ready = 1'b0;
      check("done_pulse", sel8 ? done8 : done4, 1);
      check("done_valid_low", sel8 ? if8.out_valid : if4.out_valid, 0);
      check("done_busy_low", sel8 ? busy8 : busy4, 0);
      @(negedge clk);
      check("done_one_cycle", sel8 ? done8 : done4, 0);
    end
  endtask

  // directed sequence
  initial begin
    int         n, span, trig_idx;
    logic [7:0] w0;
    bit         any_valid;

    rst = 1'b1; din = '0; din_valid = 1'b0; level = '0; force_trig = 1'b0;
    arm4 = 1'b0; arm8 = 1'b0;
    if4.out_ready = 1'b0;
    if8.out_ready = 1'b0;
    for (int i = 0; i < 400; i++)
      sine[i] = 8'(128 + int'(100.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 64.0)));

    repeat (3) @(negedge clk);
    check("rst_out_data", if4.out_data, 0);
    check("rst_out_valid", if4.out_valid, 0);
    check("rst_out_last", if4.out_last, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_busy8", busy8, 0);
    rst = 1'b0;

    // Basic trigger: ramp 0..250 step 10, level 100 -> 100..250.
    level = 8'd100;
    arm_dut(1'b0);
    for (int i = 0; i < 26; i++) drive_sample(8'(10 * i), 1'b1);
    for (int j = 0; j < 16; j++) exp_q.push_back(8'(100 + 10 * j));
    @(negedge clk); din_valid = 1'b0;
    check("entry_valid_c1", if4.out_valid, 0);
    check("entry_busy", busy4, 1);
    @(negedge clk);
    check("entry_valid_c2", if4.out_valid, 0);
    @(negedge clk);
    check("entry_valid_c3", if4.out_valid, 1);
    check("entry_data_c3", if4.out_data, 100);
    readout(1'b0, 1'b0, -1, n, span, w0);
    check("basic_count", n, 16);
    check("basic_span", span, 15);

    // No false trigger while din sits above level, then a real crossing.
    arm_dut(1'b0);
    any_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_sample(8'd200, 1'b1);
      any_valid |= if4.out_valid;
    end
    @(negedge clk);
    check("armed_busy", busy4, 1);
    check("armed_no_valid", any_valid | if4.out_valid, 0);
    drive_sample(8'd50, 1'b1);
    drive_sample(8'd150, 1'b1);
    for (int i = 1; i < 16; i++) drive_sample(8'(150 + i), 1'b1);
    for (int j = 0; j < 16; j++) exp_q.push_back(8'(150 + j));
    drive_sample(8'd0, 1'b0);
    readout(1'b0, 1'b0, -1, n, span, w0);
    check("nofalse_w0", w0, 150);
    check("nofalse_span", span, 15);

    // force_trig: level unreachable, first sample triggers.
    level = 8'd200;
    force_trig = 1'b1;
    arm_dut(1'b0);
    for (int i = 0; i < 16; i++) drive_sample(8'd5, 1'b1);
    force_trig = 1'b0;
    for (int j = 0; j < 16; j++) exp_q.push_back(8'd5);
    drive_sample(8'd0, 1'b0);
    readout(1'b0, 1'b0, -1, n, span, w0);
    check("force_count", n, 16);

    // Gapped input (1 valid in 3) and random backpressure; samples 7*k,
    // trigger on k=15 (98 -> 105).
    level = 8'd100;
    arm_dut(1'b0);
    for (int k = 0; k <= 30; k++) begin
      drive_sample(8'(7 * k), 1'b1);
      drive_sample(8'hEE, 1'b0);
      drive_sample(8'hEE, 1'b0);
    end
    for (int k = 15; k <= 30; k++) exp_q.push_back(8'(7 * k));
    readout(1'b0, 1'b1, -1, n, span, w0);
    check("gap_count", n, 16);

    // arm during capture is ignored; reset while index 7 is presented.
    arm_dut(1'b0);
    for (int i = 0; i < 26; i++) begin
      drive_sample(8'(10 * i), 1'b1);
      arm4 = (i == 15);
    end
    for (int j = 0; j < 16; j++) exp_q.push_back(8'(100 + 10 * j));
    drive_sample(8'd0, 1'b0);
    arm4 = 1'b0;
    readout(1'b0, 1'b0, 7, n, span, w0);
    check("pre_reset_xfers", n, 7);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", if4.out_valid, 0);
    check("mid_rst_busy", busy4, 0);
    check("mid_rst_last", if4.out_last, 0);
    rst = 1'b0;
    exp_q.delete();
    arm_dut(1'b0);
    for (int i = 0; i < 26; i++) drive_sample(8'(10 * i + 3), 1'b1);
    for (int j = 0; j < 16; j++) exp_q.push_back(8'(103 + 10 * j));
    drive_sample(8'd0, 1'b0);
    readout(1'b0, 1'b0, -1, n, span, w0);
    check("rearm_w0", w0, 103);
    check("rearm_count", n, 16);

    // Full depth on the 256-deep instance with a sine input, level 128.
    level = 8'd128;
    trig_idx = -1;
    for (int i = 1; i < 144; i++)
      if (trig_idx < 0 && sine[i-1] < 8'd128 && sine[i] >= 8'd128) trig_idx = i;
    arm_dut(1'b1);
    for (int i = 0; i < trig_idx + 256; i++) drive_sample(sine[i], 1'b1);
    for (int i = trig_idx; i < trig_idx + 256; i++) exp_q.push_back(sine[i]);
    drive_sample(8'd0, 1'b0);
    check("dut4_idle_during_sine", busy4, 0);
    readout(1'b1, 1'b0, -1, n, span, w0);
    check("sine_count", n, 256);
    check("sine_span", span, 255);
    check("sine_w0_ge_level", (w0 >= 8'd128), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
